// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, ALU opcodes and opcode helpers for the ALU command sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  localparam logic [3:0] OP_AND    = 4'h0;
  localparam logic [3:0] OP_OR     = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_NOR    = 4'h3;
  localparam logic [3:0] OP_NAND   = 4'h4;
  localparam logic [3:0] OP_XNOR   = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_XOR    = 4'h7;
  localparam logic [3:0] OP_LSHIFT = 4'h8;
  localparam logic [3:0] OP_RSHIFT = 4'h9;
  localparam logic [3:0] OP_LAST   = OP_RSHIFT;
  function automatic logic op_has_flag(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_LSHIFT || op == OP_RSHIFT;
  endfunction
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: command/response handshake bundle; cmd_chain exists only with ALU_SEQ_FLAG_CHAIN_EN
interface alu_seq_ctrl_if #(parameter int ANCHO = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [ANCHO-1:0] cmd_a;
  logic [ANCHO-1:0] cmd_b;
  logic             cmd_flagin;
`ifdef ALU_SEQ_FLAG_CHAIN_EN
  logic             cmd_chain;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ANCHO-1:0] rsp_result;
  logic             rsp_flag;
  logic [3:0]       rsp_op;
  logic             rsp_illegal;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_flagin, rsp_ready,
`ifdef ALU_SEQ_FLAG_CHAIN_EN
    output cmd_chain,
`endif
    input cmd_ready, rsp_valid, rsp_result, rsp_flag, rsp_op, rsp_illegal
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_a, cmd_b, cmd_flagin, rsp_ready,
`ifdef ALU_SEQ_FLAG_CHAIN_EN
    input cmd_chain,
`endif
    output cmd_ready, rsp_valid, rsp_result, rsp_flag, rsp_op, rsp_illegal
  );
endinterface

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous fall-through FIFO with wrap-bit pointers for full/empty
module alu_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign dout  = mem[rd_ptr[AW-1:0]];
  // pointer advance; a pop never frees space for a push in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage write, data needs no reset since empty gates it
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: buffers ALU commands, drives registered operands, returns results; ALU_SEQ_FLAG_CHAIN_EN adds flag chaining
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int ANCHO = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_ctrl_if.slave    bus,
  output logic [ANCHO-1:0] alu_a,
  output logic [ANCHO-1:0] alu_b,
  output logic             alu_flagin,
  output logic [3:0]       alu_control,
  input  logic [ANCHO-1:0] alu_result,
  input  logic             alu_flags
);
`ifdef ALU_SEQ_FLAG_CHAIN_EN
  localparam int CW = 1;
`else
  localparam int CW = 0;
`endif
  localparam int W = 4 + 2 * ANCHO + 1 + CW;
  state_t           state, state_n;
  logic             pop, full, empty, can_pop, fi_sel;
  logic [W-1:0]     din, dout;
  logic [3:0]       f_op;
  logic [ANCHO-1:0] f_a, f_b;
  logic             f_fi;
  logic [ANCHO-1:0] rsp_result;
  logic             rsp_flag, rsp_illegal;
  logic [3:0]       rsp_op;
`ifdef ALU_SEQ_FLAG_CHAIN_EN
  logic             f_ch, chain_flag;
  assign din = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_flagin, bus.cmd_chain};
  assign {f_op, f_a, f_b, f_fi, f_ch} = dout;
  assign fi_sel = f_ch ? chain_flag : f_fi;
`else
  assign din = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_flagin};
  assign {f_op, f_a, f_b, f_fi} = dout;
  assign fi_sel = f_fi;
`endif
  alu_seq_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.cmd_valid), .pop(pop),
    .din(din), .dout(dout), .full(full), .empty(empty)
  );
  assign bus.cmd_ready   = !full;
  assign bus.rsp_valid   = state == RESP;
  assign bus.rsp_result  = rsp_result;
  assign bus.rsp_flag    = rsp_flag;
  assign bus.rsp_op      = rsp_op;
  assign bus.rsp_illegal = rsp_illegal;
  assign can_pop = state == IDLE || (state == RESP && bus.rsp_ready);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and pop: illegal ops skip DRIVE since the ALU is not used
  always_comb begin
    state_n = state;
    pop = 1'b0;
    if (state == DRIVE) state_n = RESP;
    else if (can_pop) begin
      pop = !empty;
      state_n = empty ? IDLE : op_legal(f_op) ? DRIVE : RESP;
    end
  end
  // ALU operand load on pop and response capture at the end of DRIVE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_flagin  <= 1'b0;
      alu_control <= '0;
      rsp_result  <= '0;
      rsp_flag    <= 1'b0;
      rsp_op      <= '0;
      rsp_illegal <= 1'b0;
    end else if (pop && op_legal(f_op)) begin
      alu_a       <= f_a;
      alu_b       <= f_b;
      alu_flagin  <= fi_sel;
      alu_control <= f_op;
    end else if (pop) begin
      rsp_result  <= '0;
      rsp_flag    <= 1'b0;
      rsp_op      <= f_op;
      rsp_illegal <= 1'b1;
    end else if (state == DRIVE) begin
      rsp_result  <= alu_result;
      rsp_flag    <= op_has_flag(alu_control) && alu_flags;
      rsp_op      <= alu_control;
      rsp_illegal <= 1'b0;
    end
`ifdef ALU_SEQ_FLAG_CHAIN_EN
  // remembers the flag of the last flag-producing op for chained commands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain_flag <= 1'b0;
    else if (state == DRIVE && op_has_flag(alu_control)) chain_flag <= alu_flags;
`endif
endmodule
